// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and timing constants for the key conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_cond_pkg;

    // Per-channel press/release state
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } key_state_t;

    // Board timing at 50 MHz: 10 ms debounce, 0.5 s repeat delay, 100 ms repeat rate
    localparam int DEF_DEBOUNCE_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

    // Short values that keep simulations fast
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int SIM_REPEAT_DELAY_CYCLES = 20;
    localparam int SIM_REPEAT_RATE_CYCLES  = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key: 2-flop sync, debounce FSM, press/release pulses.
// Latency: pulse DEBOUNCE_CYCLES+2 cycles after a stable level change on i_key_n.
// Backpressure: none; pulses are single-cycle and unconditional. Auto-repeat with KEY_AUTOREPEAT_EN.
module key_debounce_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    // Reject timing values that would make the counters meaningless
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
        $error("key_debounce_channel: timing parameters must be >= 1");
    end

    logic             r_sync1, r_sync2;
    logic             w_s;
    key_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_cnt_done;
    logic             r_level, r_press, r_release;
    logic             w_level_nxt, w_press_nxt, w_release_nxt;
    logic             w_rep_fire;

    // Two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s        = ~r_sync2;
    // The sample that opens a pending state is not counted, so D more are needed
    assign w_cnt_done = (r_cnt >= CNT_LAST);
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // State register, debounce counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RELEASED: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESS_PEND;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!w_s)           w_state_nxt = ST_RELEASED;
                else if (w_cnt_done) w_state_nxt = ST_PRESSED;
                else                w_cnt_nxt   = w_cnt_inc;
            end
            ST_PRESSED: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASE_PEND;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_PEND: begin
                if (w_s)            w_state_nxt = ST_PRESSED;
                else if (w_cnt_done) w_state_nxt = ST_RELEASED;
                else                w_cnt_nxt   = w_cnt_inc;
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: press only from PRESS_PEND or repeat, release only from RELEASE_PEND
    always_comb begin
        w_level_nxt   = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_PEND);
        w_press_nxt   = ((r_state == ST_PRESS_PEND) && w_s && w_cnt_done) || w_rep_fire;
        w_release_nxt = (r_state == ST_RELEASE_PEND) && !w_s && w_cnt_done;
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             w_held, w_rep_step;

    // Only cycles with the key seen down advance the count; a bounce toward release freezes it
    assign w_held     = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_PEND);
    assign w_rep_step = w_held && w_s;
    assign w_rep_fire = w_rep_step && (r_rep_cnt == (r_rep_armed ? REP_NEXT : REP_FIRST));

    // Repeat counter: first interval is the delay, later ones the rate; cleared once released
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_held) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_step) begin
            if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS independent debounced key channels (optional KEY_AUTOREPEAT_EN).
// Latency: key_press/key_release DEBOUNCE_CYCLES+2 cycles after a stable key_n change.
// Backpressure: none; consumers must take single-cycle pulses as they occur.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS            = 2,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic                MAX10_CLK1_50,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    // One fully independent channel per key
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_chan (
            .i_clk     (MAX10_CLK1_50),
            .i_rst     (rst),
            .i_key_n   (key_n[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random key waveforms scored against a behavioural model.
// Latency: model expects pulses DEBOUNCE+2 cycles after a stable change.
// Backpressure: none.
module tb_key_conditioner;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_level, key_press, key_release;

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
    ) dut (
        .MAX10_CLK1_50(clk), .rst(rst), .key_n(key_n),
        .key_level(key_level), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lvl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Behavioural model: a level flips once s has disagreed with it for D+1 straight cycles
    logic [NK-1:0] m_p1 = '1, m_p2 = '1, m_lvl = '0;
    int            m_run[NK];
    int            m_hold[NK];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic s;
        e.cyc = cyc; e.press = '0; e.rel = '0;
        if (rst) begin
            m_p1 = '1; m_p2 = '1; m_lvl = '0;
            for (int c = 0; c < NK; c++) begin m_run[c] = 0; m_hold[c] = 0; end
        end else begin
            for (int c = 0; c < NK; c++) begin
                s = ~m_p2[c];
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        m_run[c]  = 0;
                        m_hold[c] = 0;
                        m_lvl[c]  = s;
                        if (s) e.press[c] = 1'b1;
                        else   e.rel[c]   = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                    if (AR && m_lvl[c]) begin
                        m_hold[c]++;
                        if (m_hold[c] >= RD && ((m_hold[c] - RD) % RR) == 0) e.press[c] = 1'b1;
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = key_n;
        end
        e.lvl = m_lvl;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        model_step();
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) tick();
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || key_press !== mon_e.press || key_release !== mon_e.rel
                || key_level !== mon_e.lvl) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d (entry %0d) actual press=%b rel=%b lvl=%b required press=%b rel=%b lvl=%b",
                         cyc, mon_e.cyc, key_press, key_release, key_level,
                         mon_e.press, mon_e.rel, mon_e.lvl);
            end
            checks++;
            if ((key_press & key_release) !== '0) begin
                failures++;
                $display("FAIL press_release_overlap cyc=%0d actual=%b required=00", cyc, key_press & key_release);
            end
        end
    end

    int bounce_pulses;
    int dur[NK];

    initial begin
        for (int c = 0; c < NK; c++) begin m_run[c] = 0; m_hold[c] = 0; dur[c] = 0; end

        // Reset state
        to_edge(1);
        chk("reset_level", 32'(key_level), 32'h0);
        chk("reset_press", 32'(key_press), 32'h0);
        chk("reset_release", 32'(key_release), 32'h0);
        to_edge(3);
        rst = 1'b0;

        // Clean press on key 0: low from edge 10
        to_edge(9);  key_n[0] = 1'b0;
        to_edge(15); chk("press_early", 32'(key_press), 32'h0);
        to_edge(16); chk("press_at_16", 32'(key_press), 32'h1);
                     chk("level_at_16", 32'(key_level), 32'h1);
        to_edge(17); chk("press_after", 32'(key_press), 32'h0);
        to_edge(36); chk("repeat_36", 32'(key_press), AR ? 32'h1 : 32'h0);
        to_edge(44); chk("repeat_44", 32'(key_press), AR ? 32'h1 : 32'h0);

        // Release: high from edge 50
        to_edge(49); key_n[0] = 1'b1;
        to_edge(55); chk("release_early", 32'(key_release), 32'h0);
        to_edge(56); chk("release_at_56", 32'(key_release), 32'h1);
                     chk("level_rel_56", 32'(key_level), 32'h0);

        // Bounce: toggle every 2 cycles for 20 cycles, then stable low from edge 90
        bounce_pulses = 0;
        to_edge(69);
        for (int i = 0; i < 20; i++) begin
            key_n[0] = ((i / 2) % 2) != 0;
            tick();
            bounce_pulses += int'(key_press[0]);
        end
        key_n[0] = 1'b0;
        while (cyc < 95) begin tick(); bounce_pulses += int'(key_press[0]); end
        chk("bounce_no_pulse", 32'(bounce_pulses), 32'h0);
        to_edge(96); chk("bounce_press_96", 32'(key_press), 32'h1);
        to_edge(109); key_n[0] = 1'b1;
        to_edge(116); chk("bounce_release_116", 32'(key_release), 32'h1);

        // Simultaneous press of both keys from edge 130
        to_edge(129); key_n = 2'b00;
        to_edge(136); chk("simul_press_136", 32'(key_press), 32'h3);
        to_edge(137); chk("simul_press_137", 32'(key_press), 32'h0);
        to_edge(199); key_n = 2'b11;
        to_edge(206); chk("simul_release_206", 32'(key_release), 32'h3);

        // Reset during PRESS_PEND
        to_edge(229); key_n[0] = 1'b0;
        to_edge(233); rst = 1'b1;
        to_edge(234); rst = 1'b0;
                      chk("rst_pend_out", 32'({key_level, key_press, key_release}), 32'h0);
        to_edge(240); chk("rst_pend_early", 32'(key_press), 32'h0);
        to_edge(241); chk("rst_pend_press_241", 32'(key_press), 32'h1);

        // Reset during PRESSED with the key held
        to_edge(249); rst = 1'b1;
        to_edge(250); rst = 1'b0;
                      chk("rst_hold_out", 32'({key_level, key_press, key_release}), 32'h0);
        to_edge(256); chk("rst_hold_early", 32'(key_press), 32'h0);
        to_edge(257); chk("rst_hold_press_257", 32'(key_press), 32'h1);
                      chk("rst_hold_level_257", 32'(key_level), 32'h1);
        to_edge(269); key_n = 2'b11;
        to_edge(300);

        // Random phase: short glitches, medium and long holds, rare resets
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NK; c++) begin
                if (dur[c] == 0) begin
                    key_n[c] = ~key_n[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 60))
                                                         : int'($urandom_range(1, 9));
                end
                dur[c]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        key_n = '1;
        repeat (30) tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
